// File: rtl/edge_evt_pkg.sv
// Shared constants, event payload type and round-robin helper for the edge-event arbiter.
package edge_evt_pkg;

   localparam int unsigned DEF_N_CH        = 4;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   // Channel field wide enough for the largest supported channel count (16).
   localparam int unsigned EVT_CH_W = 4;

   localparam logic EDGE_RISE = 1'b1;
   localparam logic EDGE_FALL = 1'b0;

   typedef struct packed {
      logic [EVT_CH_W-1:0] ch;
      logic                rise;
   } edge_evt_t;

   // (base + off) wrapped into 0..n-1; both operands are assumed already below n.
   function automatic int unsigned rr_wrap(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
      int unsigned s;
      s = base + off;
      if (s >= n) begin
         s = s - n;
      end
      return s;
   endfunction

endpackage

// File: rtl/edge_capture.sv
// Per-channel synchronizer, edge detector, single-entry pending slot and sticky overrun flag.
module edge_capture
   import edge_evt_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   input  logic en_rise,
   input  logic en_fall,
   input  logic take,
   input  logic clr,
   output logic pend,
   output logic pend_rise,
   output logic overrun
);

   logic cur_c;
   logic prev_q;
   logic pend_q, pend_d;
   logic pend_rise_q, pend_rise_d;
   logic overrun_q, overrun_d;
   logic qual_c;
   logic free_c;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign cur_c = sig;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         // Shift chain toward the MSB; the MSB is the synchronized level.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q <= (sync_q << 1) | SYNC_STAGES'(sig);
            end
         end

         assign cur_c = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Edge qualification and slot/overrun next state; a take in the same cycle frees the slot for a new edge.
   always_comb begin
      qual_c      = (cur_c ^ prev_q) & (cur_c ? en_rise : en_fall);
      free_c      = ~pend_q | take;
      pend_d      = pend_q & ~take;
      pend_rise_d = pend_rise_q;
      overrun_d   = overrun_q & ~clr;
      if (qual_c) begin
         if (free_c) begin
            pend_d      = 1'b1;
            pend_rise_d = cur_c ? EDGE_RISE : EDGE_FALL;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_rise_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         prev_q      <= cur_c;
         pend_q      <= pend_d;
         pend_rise_q <= pend_rise_d;
         overrun_q   <= overrun_d;
      end
   end

   assign pend      = pend_q;
   assign pend_rise = pend_rise_q;
   assign overrun   = overrun_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel capture, round-robin select, registered valid/ready output.
module edge_event_arbiter
   import edge_evt_pkg::*;
#(
   parameter  int unsigned N_CH        = DEF_N_CH,
   parameter  int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   localparam int unsigned CW          = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] signal_in,
   input  logic [N_CH-1:0] en_rise,
   input  logic [N_CH-1:0] en_fall,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [CW-1:0]   evt_ch,
   output logic            evt_rise,
   output logic [N_CH-1:0] evt_overrun,
   input  logic            clr_overrun
);

   logic [N_CH-1:0] pend_c;
   logic [N_CH-1:0] pend_rise_c;
   logic [N_CH-1:0] take_c;
   logic [CW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   idx_c;
   logic [CW-1:0]   win_c;
   logic            found_c;
   logic            load_c;
   logic            valid_q, valid_d;
   edge_evt_t       evt_q, evt_d;
   logic            unused_ch_c;

   genvar g;
   generate
      for (g = 0; g < N_CH; g++) begin : g_ch
         edge_capture #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_cap (
            .clk       (clk),
            .rst       (rst),
            .sig       (signal_in[g]),
            .en_rise   (en_rise[g]),
            .en_fall   (en_fall[g]),
            .take      (take_c[g]),
            .clr       (clr_overrun),
            .pend      (pend_c[g]),
            .pend_rise (pend_rise_c[g]),
            .overrun   (evt_overrun[g])
         );
      end
   endgenerate

   // Round-robin search over full slots starting at ptr.
   always_comb begin
      found_c = 1'b0;
      win_c   = '0;
      idx_c   = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx_c = CW'(rr_wrap(32'(ptr_q), i, N_CH));
         if (!found_c && pend_c[idx_c]) begin
            found_c = 1'b1;
            win_c   = idx_c;
         end
      end
   end

   // Output register load, slot take and pointer advance.
   always_comb begin
      load_c  = ~valid_q | evt_ready;
      take_c  = '0;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      evt_d   = evt_q;
      if (load_c) begin
         valid_d = found_c;
         if (found_c) begin
            take_c[win_c] = 1'b1;
            ptr_d         = CW'(rr_wrap(32'(win_c), 1, N_CH));
            evt_d.ch      = EVT_CH_W'(win_c);
            evt_d.rise    = pend_rise_c[win_c];
         end
      end
   end

   // Arbiter state and presented event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         evt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         evt_q   <= evt_d;
      end
   end

   // Channel field is sized for 16 channels; upper bits stay zero for smaller N_CH.
   assign unused_ch_c = ^evt_q.ch;

   assign evt_valid = valid_q;
   assign evt_ch    = evt_q.ch[CW-1:0];
   assign evt_rise  = evt_q.rise;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (N_CH=4, SYNC_STAGES=2).
module tb_edge_event_arbiter;

   localparam int unsigned N_CH = 4;
   localparam int unsigned CW   = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N_CH-1:0] signal_in;
   logic [N_CH-1:0] en_rise;
   logic [N_CH-1:0] en_fall;
   logic            evt_valid;
   logic            evt_ready;
   logic [CW-1:0]   evt_ch;
   logic            evt_rise;
   logic [N_CH-1:0] evt_overrun;
   logic            clr_overrun;

   int n_checks = 0;
   int n_fail   = 0;

   edge_event_arbiter #(
      .N_CH        (N_CH),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .signal_in   (signal_in),
      .en_rise     (en_rise),
      .en_fall     (en_fall),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_ch      (evt_ch),
      .evt_rise    (evt_rise),
      .evt_overrun (evt_overrun),
      .clr_overrun (clr_overrun)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_evt(input string tag, input int ch, input logic rise);
      check({tag, "_valid"}, 32'(evt_valid), 32'd1);
      check({tag, "_ch"},    32'(evt_ch),    32'(ch));
      check({tag, "_rise"},  32'(evt_rise),  32'(rise));
   endtask

   // Drives all channels to lvl and expects a burst served in the given order.
   task automatic burst(input string tag, input logic [N_CH-1:0] lvl, input logic rise,
                        input int o0, input int o1, input int o2, input int o3);
      int order [4];
      order = '{o0, o1, o2, o3};
      signal_in = lvl;
      tick(3);
      check({tag, "_lat"}, 32'(evt_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick(1);
         check_evt(tag, order[k], rise);
      end
      tick(1);
      check({tag, "_idle"}, 32'(evt_valid), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      signal_in   = '0;
      en_rise     = '1;
      en_fall     = '1;
      evt_ready   = 1'b1;
      clr_overrun = 1'b0;
      tick(3);
      check("rst_valid",   32'(evt_valid),   32'd0);
      check("rst_ch",      32'(evt_ch),      32'd0);
      check("rst_rise",    32'(evt_rise),    32'd0);
      check("rst_overrun", 32'(evt_overrun), 32'd0);
      rst = 1'b0;

      // Simultaneous bursts with ptr at 0.
      burst("rr0_rise", 4'b1111, 1'b1, 0, 1, 2, 3);
      burst("rr0_fall", 4'b0000, 1'b0, 0, 1, 2, 3);

      // Single edges on ch1; leaves ptr at 2.
      signal_in = 4'b0010;
      tick(3);
      check("single_r_lat", 32'(evt_valid), 32'd0);
      tick(1);
      check_evt("single_r", 1, 1'b1);
      tick(1);
      check("single_r_idle", 32'(evt_valid), 32'd0);
      signal_in = 4'b0000;
      tick(3);
      check("single_f_lat", 32'(evt_valid), 32'd0);
      tick(1);
      check_evt("single_f", 1, 1'b0);
      tick(1);
      check("single_f_idle", 32'(evt_valid), 32'd0);

      // Bursts starting from ptr 2.
      burst("rr2_rise", 4'b1111, 1'b1, 2, 3, 0, 1);
      burst("rr2_fall", 4'b0000, 1'b0, 2, 3, 0, 1);

      // Backpressure on ch2.
      evt_ready = 1'b0;
      signal_in = 4'b0100;
      tick(4);
      check_evt("bp_first", 2, 1'b1);
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check_evt("bp_hold", 2, 1'b1);
      end
      evt_ready = 1'b1;
      tick(1);
      check("bp_done", 32'(evt_valid), 32'd0);

      // Overrun: ch0 blocks the output, ch3 rise fills its slot, ch3 fall is dropped.
      evt_ready = 1'b0;
      signal_in = 4'b0101;
      tick(4);
      check_evt("ovr_block", 0, 1'b1);
      signal_in = 4'b1101;
      tick(2);
      signal_in = 4'b0101;
      tick(2);
      check("ovr_before", 32'(evt_overrun), 32'h0);
      tick(1);
      check("ovr_set", 32'(evt_overrun), 32'h8);
      check_evt("ovr_hold", 0, 1'b1);
      evt_ready = 1'b1;
      tick(1);
      check_evt("ovr_deliver", 3, 1'b1);
      tick(1);
      check("ovr_no_fall", 32'(evt_valid), 32'd0);
      check("ovr_sticky", 32'(evt_overrun), 32'h8);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      check("ovr_clr", 32'(evt_overrun), 32'h0);

      // Drop coinciding with clr: set wins.
      evt_ready = 1'b0;
      signal_in = 4'b0111;
      tick(4);
      check_evt("ovr2_block", 1, 1'b1);
      signal_in = 4'b1111;
      tick(2);
      signal_in = 4'b0111;
      tick(2);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      check("ovr2_set_wins", 32'(evt_overrun), 32'h8);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      check("ovr2_clr", 32'(evt_overrun), 32'h0);
      evt_ready = 1'b1;
      tick(1);
      check_evt("ovr2_deliver", 3, 1'b1);
      tick(1);
      check("ovr2_idle", 32'(evt_valid), 32'd0);

      // Falling edge on ch0 disabled: only the following rise is delivered.
      en_fall   = 4'b1110;
      signal_in = 4'b0110;
      tick(2);
      signal_in = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("en_fall_off", 32'(evt_valid), 32'd0);
      end
      tick(1);
      check_evt("en_fall_rise", 0, 1'b1);
      tick(1);
      check("en_fall_idle", 32'(evt_valid), 32'd0);
      en_fall = '1;

      // All rising edges disabled.
      en_rise   = '0;
      signal_in = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         check("en_rise_off", 32'(evt_valid), 32'd0);
      end
      en_rise = '1;

      // Reset with one event presented and three pending.
      evt_ready = 1'b0;
      signal_in = 4'b0000;
      tick(5);
      check_evt("rstm_pre", 1, 1'b0);
      rst       = 1'b1;
      signal_in = 4'b0100;
      #1;
      check("rstm_async_valid", 32'(evt_valid),   32'd0);
      check("rstm_async_ovr",   32'(evt_overrun), 32'h0);
      tick(2);
      rst       = 1'b0;
      evt_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("rstm_quiet", 32'(evt_valid), 32'd0);
      end
      tick(1);
      check_evt("rstm_high", 2, 1'b1);
      for (int k = 0; k < 6; k++) begin
         tick(1);
         check("rstm_no_stale", 32'(evt_valid), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
